// File: rtl/mem_dispatcher_pkg.sv
// Shared definitions for the MCB line dispatchers: FSM encoding, MCB instruction codes,
// and the settle time allowed for the MCB FIFO status flags.
package mem_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL       = 2'd1,
    CMD        = 2'd2,
    WAIT_EMPTY = 2'd3
  } disp_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Cycles after a command during which the MCB FIFO empty flag is not yet trustworthy.
  localparam int GUARD_LEN = 4;

endpackage

// File: rtl/mem_dispatcher__write_if.sv
// Line-buffer read side plus one MCB user port (command + write FIFO) of a write dispatcher.
// master = dispatcher side, slave = line buffer / MCB side.
interface mem_dispatcher__write_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic [AW-1:0] data_in__addr;
  logic [DW-1:0] data_in;
  logic          port_cmd_en;
  logic [2:0]    port_cmd_instr;
  logic [5:0]    port_cmd_bl;
  logic [29:0]   port_cmd_byte_addr;
  logic          port_wr_en;
  logic [DW-1:0] port_wr_data_out;
  logic          port_wr_full;
  logic          port_wr_empty;

  modport master (
    output data_in__addr,
    input  data_in,
    output port_cmd_en,
    output port_cmd_instr,
    output port_cmd_bl,
    output port_cmd_byte_addr,
    output port_wr_en,
    output port_wr_data_out,
    input  port_wr_full,
    input  port_wr_empty
  );

  modport slave (
    input  data_in__addr,
    output data_in,
    input  port_cmd_en,
    input  port_cmd_instr,
    input  port_cmd_bl,
    input  port_cmd_byte_addr,
    input  port_wr_en,
    input  port_wr_data_out,
    output port_wr_full,
    output port_wr_empty
  );

endinterface

// File: rtl/mem_dispatcher__write.sv
// Streams WORDS_TO_WRITE line-buffer words into an MCB write port in bursts of <= FIFO_LENGTH; first push 2 cycles after start.
// Backpressure: port_wr_full parks the in-flight word in a one-entry hold register and stalls address issue; MEM_DISPATCHER_WR_STATS_EN adds stall_cycles.
module mem_dispatcher__write
  import mem_dispatcher_pkg::*;
#(
  parameter int FIFO_LENGTH    = 64,
  parameter int WORDS_TO_WRITE = 640,
  parameter int BUFF_ADDR_BITS = 10,
  parameter int PORT_64_BITS   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        os_start,
  input  logic [29:0] init_mem_addr,
  output logic        busy_write_unit,
  input  logic        mem_calib_done,
`ifdef MEM_DISPATCHER_WR_STATS_EN
  output logic [15:0] stall_cycles,
`endif
  mem_dispatcher__write_if.master mcb
);

  localparam int DW        = 32 * (1 + PORT_64_BITS);
  localparam int BPW       = 4 * (1 + PORT_64_BITS);
  localparam int REM_W     = $clog2(WORDS_TO_WRITE + 1);
  localparam int FIRST_INT = (WORDS_TO_WRITE < FIFO_LENGTH) ? WORDS_TO_WRITE : FIFO_LENGTH;
  localparam logic [6:0] FIRST_LEN = 7'(FIRST_INT);

  disp_state_t state, state_nxt;

  logic [29:0]               cur_addr;
  logic [REM_W-1:0]          remaining;
  logic [6:0]                burst_len;
  logic [BUFF_ADDR_BITS-1:0] buf_ptr;
  logic [6:0]                issue_cnt;
  logic [6:0]                push_cnt;
  logic [2:0]                guard_cnt;
  logic                      rd_vld;
  logic                      hold_vld;
  logic [DW-1:0]             hold_dat;
  logic [DW-1:0]             last_dat;

  logic          accept;
  logic          word_rdy;
  logic [DW-1:0] cur_word;
  logic          push;
  logic          issue;
  logic          last_push;
  logic          burst_done;
  logic          guard_done;
  logic [6:0]    next_len;

  assign accept     = (state == IDLE) && os_start && mem_calib_done;
  assign word_rdy   = hold_vld || rd_vld;
  assign cur_word   = hold_vld ? hold_dat : mcb.data_in;
  assign push       = (state == FILL) && word_rdy && !mcb.port_wr_full;
  // Only fetch another word when the one arriving now (if any) can leave this cycle,
  // so the hold register never needs a second entry.
  assign issue      = (state == FILL) && (issue_cnt != burst_len) &&
                      !(word_rdy && mcb.port_wr_full);
  assign last_push  = push && (push_cnt == (burst_len - 7'd1));
  assign burst_done = (remaining == REM_W'(burst_len));
  assign guard_done = (guard_cnt == 3'(GUARD_LEN));
  assign next_len   = (32'(remaining) < 32'(FIFO_LENGTH)) ? 7'(remaining) : 7'(FIFO_LENGTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt              = state;
    busy_write_unit        = (state != IDLE);
    mcb.data_in__addr      = buf_ptr;
    mcb.port_cmd_en        = 1'b0;
    mcb.port_cmd_instr     = CMD_WRITE;
    mcb.port_cmd_bl        = 6'd0;
    mcb.port_cmd_byte_addr = 30'd0;
    mcb.port_wr_en         = push;
    mcb.port_wr_data_out   = push ? cur_word : last_dat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (last_push) begin
          state_nxt = CMD;
        end
      end
      CMD: begin
        mcb.port_cmd_en        = 1'b1;
        mcb.port_cmd_bl        = 6'(burst_len - 7'd1);
        mcb.port_cmd_byte_addr = cur_addr;
        state_nxt              = burst_done ? IDLE : WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        if (guard_done && mcb.port_wr_empty) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      burst_len <= '0;
      buf_ptr   <= '0;
      issue_cnt <= '0;
      push_cnt  <= '0;
      guard_cnt <= '0;
      rd_vld    <= 1'b0;
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
      last_dat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr  <= init_mem_addr;
            remaining <= REM_W'(WORDS_TO_WRITE);
            buf_ptr   <= '0;
            burst_len <= FIRST_LEN;
            issue_cnt <= '0;
            push_cnt  <= '0;
            rd_vld    <= 1'b0;
            hold_vld  <= 1'b0;
          end
        end
        FILL: begin
          rd_vld <= issue;
          if (issue) begin
            buf_ptr   <= buf_ptr + 1'b1;
            issue_cnt <= issue_cnt + 7'd1;
          end
          if (push) begin
            push_cnt <= push_cnt + 7'd1;
            last_dat <= cur_word;
          end
          if (hold_vld && !mcb.port_wr_full) begin
            hold_vld <= 1'b0;
          end else if (!hold_vld && rd_vld && mcb.port_wr_full) begin
            hold_vld <= 1'b1;
            hold_dat <= mcb.data_in;
          end
        end
        CMD: begin
          cur_addr  <= cur_addr + (30'(burst_len) * 30'(BPW));
          remaining <= remaining - REM_W'(burst_len);
          guard_cnt <= '0;
        end
        WAIT_EMPTY: begin
          if (!guard_done) begin
            guard_cnt <= guard_cnt + 3'd1;
          end else if (mcb.port_wr_empty) begin
            burst_len <= next_len;
            issue_cnt <= '0;
            push_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_DISPATCHER_WR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      stall_cycles <= '0;
    end else if ((state == FILL) && word_rdy && mcb.port_wr_full &&
                 (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dispatcher__write.sv
// Directed bench for mem_dispatcher__write: three instances (default, 100-word, 64-bit port)
// sharing clock/reset, with a registered line-buffer model and a negedge transaction log.
module tb_mem_dispatcher__write;

  logic        c3_clk0 = 1'b0;
  logic        reset = 1'b1;
  logic        calib = 1'b1;
  logic        full = 1'b0;
  logic        empty = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [29:0] init_addr = 30'd0;
  logic        busy_a, busy_b, busy_c;
`ifdef MEM_DISPATCHER_WR_STATS_EN
  logic [15:0] stall_a, stall_b, stall_c;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int sel = 0;

  always #5 c3_clk0 = ~c3_clk0;
  always @(posedge c3_clk0) cyc <= cyc + 1;

  mem_dispatcher__write_if #(.DW(32), .AW(10)) ifa ();
  mem_dispatcher__write_if #(.DW(32), .AW(10)) ifb ();
  mem_dispatcher__write_if #(.DW(64), .AW(10)) ifc ();

  assign ifa.port_wr_full = full;
  assign ifb.port_wr_full = full;
  assign ifc.port_wr_full = full;
  assign ifa.port_wr_empty = empty;
  assign ifb.port_wr_empty = empty;
  assign ifc.port_wr_empty = empty;

  mem_dispatcher__write dut_a (
    .clk(c3_clk0), .reset(reset), .os_start(start_a), .init_mem_addr(init_addr),
    .busy_write_unit(busy_a), .mem_calib_done(calib),
`ifdef MEM_DISPATCHER_WR_STATS_EN
    .stall_cycles(stall_a),
`endif
    .mcb(ifa)
  );

  mem_dispatcher__write #(.WORDS_TO_WRITE(100)) dut_b (
    .clk(c3_clk0), .reset(reset), .os_start(start_b), .init_mem_addr(init_addr),
    .busy_write_unit(busy_b), .mem_calib_done(calib),
`ifdef MEM_DISPATCHER_WR_STATS_EN
    .stall_cycles(stall_b),
`endif
    .mcb(ifb)
  );

  mem_dispatcher__write #(.PORT_64_BITS(1), .FIFO_LENGTH(64), .WORDS_TO_WRITE(128)) dut_c (
    .clk(c3_clk0), .reset(reset), .os_start(start_c), .init_mem_addr(init_addr),
    .busy_write_unit(busy_c), .mem_calib_done(calib),
`ifdef MEM_DISPATCHER_WR_STATS_EN
    .stall_cycles(stall_c),
`endif
    .mcb(ifc)
  );

  function automatic logic [31:0] word_lo(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  function automatic logic [31:0] word_hi(input logic [9:0] a);
    return 32'hBEEF_0000 | {22'd0, a};
  endfunction

  function automatic logic [63:0] exp_word(input int i, input bit wide);
    logic [9:0] a;
    a = 10'(i);
    return wide ? {word_hi(a), word_lo(a)} : {32'd0, word_lo(a)};
  endfunction

  // Line buffer: data valid one cycle after its address.
  always @(posedge c3_clk0) begin
    ifa.data_in <= word_lo(ifa.data_in__addr);
    ifb.data_in <= word_lo(ifb.data_in__addr);
    ifc.data_in <= {word_hi(ifc.data_in__addr), word_lo(ifc.data_in__addr)};
  end

  logic        m_wr, m_cmd, m_busy;
  logic [63:0] m_dat;
  logic [5:0]  m_bl;
  logic [29:0] m_ad;
  logic [9:0]  m_addr;
  logic [2:0]  m_instr;

  always_comb begin
    m_wr = ifa.port_wr_en; m_cmd = ifa.port_cmd_en; m_busy = busy_a;
    m_dat = {32'd0, ifa.port_wr_data_out}; m_bl = ifa.port_cmd_bl;
    m_ad = ifa.port_cmd_byte_addr; m_addr = ifa.data_in__addr; m_instr = ifa.port_cmd_instr;
    if (sel == 1) begin
      m_wr = ifb.port_wr_en; m_cmd = ifb.port_cmd_en; m_busy = busy_b;
      m_dat = {32'd0, ifb.port_wr_data_out}; m_bl = ifb.port_cmd_bl;
      m_ad = ifb.port_cmd_byte_addr; m_addr = ifb.data_in__addr; m_instr = ifb.port_cmd_instr;
    end else if (sel == 2) begin
      m_wr = ifc.port_wr_en; m_cmd = ifc.port_cmd_en; m_busy = busy_c;
      m_dat = ifc.port_wr_data_out; m_bl = ifc.port_cmd_bl;
      m_ad = ifc.port_cmd_byte_addr; m_addr = ifc.data_in__addr; m_instr = ifc.port_cmd_instr;
    end
  end

  logic [63:0] push_q[$];
  int          push_cyc_q[$];
  logic [5:0]  bl_q[$];
  logic [29:0] ad_q[$];
  int          cmd_cyc_q[$];
  int          fall_cyc = -1;
  logic        busy_prev = 1'b0;

  always @(negedge c3_clk0) begin
    if (m_wr === 1'b1) begin
      push_q.push_back(m_dat);
      push_cyc_q.push_back(cyc);
    end
    if (m_cmd === 1'b1) begin
      bl_q.push_back(m_bl);
      ad_q.push_back(m_ad);
      cmd_cyc_q.push_back(cyc);
    end
    if (busy_prev === 1'b1 && m_busy === 1'b0) fall_cyc = cyc;
    busy_prev = m_busy;
  end

  task automatic tick();
    @(posedge c3_clk0);
    #1;
  endtask

  task automatic clear_logs();
    push_q.delete(); push_cyc_q.delete();
    bl_q.delete(); ad_q.delete(); cmd_cyc_q.delete();
    fall_cyc = -1;
  endtask

  task automatic pulse_start(input int which, input logic [29:0] a);
    init_addr = a;
    if (which == 0) start_a = 1'b1;
    else if (which == 1) start_b = 1'b1;
    else start_c = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int k = 0;
    while (m_busy !== 1'b0 && k < bound) begin
      @(negedge c3_clk0);
      k++;
    end
    ok = (m_busy === 1'b0);
    tick();
  endtask

  task automatic wait_pushes(input int n, input int bound, output bit ok);
    int k = 0;
    while (push_q.size() < n && k < bound) begin
      @(negedge c3_clk0);
      k++;
    end
    ok = (push_q.size() >= n);
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b1;
    repeat (3) tick();
    @(negedge c3_clk0);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_checks++; if (ifa.data_in__addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", ifa.data_in__addr); end
    n_checks++; if (ifa.port_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en got %b want 0", ifa.port_cmd_en); end
    n_checks++; if (ifa.port_cmd_bl !== 6'd0) begin n_fail++; $display("FAIL reset_bl got %0d want 0", ifa.port_cmd_bl); end
    n_checks++; if (ifa.port_cmd_byte_addr !== 30'd0) begin n_fail++; $display("FAIL reset_byte_addr got %h want 0", ifa.port_cmd_byte_addr); end
    n_checks++; if (ifa.port_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", ifa.port_wr_en); end
    n_checks++; if (ifa.port_wr_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_wr_data got %h want 0", ifa.port_wr_data_out); end
    n_checks++; if (ifa.port_cmd_instr !== 3'b000) begin n_fail++; $display("FAIL reset_instr got %b want 000", ifa.port_cmd_instr); end
    n_checks++; if ({busy_b, busy_c} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_bc got %b want 00", {busy_b, busy_c}); end
`ifdef MEM_DISPATCHER_WR_STATS_EN
    n_checks++; if (stall_a !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_a); end
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_line();
    bit ok;
    sel = 0;
    clear_logs();
    pulse_start(0, 30'h0000A000);
    @(negedge c3_clk0);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL line_busy_n1 got %b want 1", busy_a); end
    n_checks++; if (ifa.data_in__addr !== 10'd0) begin n_fail++; $display("FAIL line_addr_n1 got %0d want 0", ifa.data_in__addr); end
    n_checks++; if (ifa.port_wr_en !== 1'b0) begin n_fail++; $display("FAIL line_wr_en_n1 got %b want 0", ifa.port_wr_en); end
    @(negedge c3_clk0);
    n_checks++; if (ifa.port_wr_en !== 1'b1) begin n_fail++; $display("FAIL line_wr_en_n2 got %b want 1", ifa.port_wr_en); end
    n_checks++; if (ifa.port_wr_data_out !== word_lo(10'd0)) begin n_fail++; $display("FAIL line_first_data got %h want %h", ifa.port_wr_data_out, word_lo(10'd0)); end
    wait_idle(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL line_timeout busy still %b want 0", m_busy); end
    n_checks++; if (bl_q.size() !== 10) begin n_fail++; $display("FAIL line_cmd_count got %0d want 10", bl_q.size()); end
    for (int i = 0; i < bl_q.size(); i++) begin
      n_checks++; if (bl_q[i] !== 6'd63) begin n_fail++; $display("FAIL line_bl[%0d] got %0d want 63", i, bl_q[i]); end
      n_checks++; if (ad_q[i] !== 30'(32'hA000 + i * 256)) begin n_fail++; $display("FAIL line_addr[%0d] got %h want %h", i, ad_q[i], 32'hA000 + i * 256); end
    end
    n_checks++; if (push_q.size() !== 640) begin n_fail++; $display("FAIL line_push_count got %0d want 640", push_q.size()); end
    for (int i = 0; i < push_q.size(); i++) begin
      n_checks++; if (push_q[i] !== exp_word(i, 1'b0)) begin n_fail++; $display("FAIL line_data[%0d] got %h want %h", i, push_q[i], exp_word(i, 1'b0)); end
    end
    if (cmd_cyc_q.size() > 0) begin
      n_checks++; if (fall_cyc !== cmd_cyc_q[$] + 1) begin n_fail++; $display("FAIL line_busy_fall got cycle %0d want %0d", fall_cyc, cmd_cyc_q[$] + 1); end
    end
  endtask

  task automatic test_short_block();
    bit ok;
    sel = 1;
    clear_logs();
    pulse_start(1, 30'd0);
    wait_idle(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL short_timeout busy still %b want 0", m_busy); end
    n_checks++; if (bl_q.size() !== 2) begin n_fail++; $display("FAIL short_cmd_count got %0d want 2", bl_q.size()); end
    if (bl_q.size() == 2) begin
      n_checks++; if (bl_q[0] !== 6'd63) begin n_fail++; $display("FAIL short_bl0 got %0d want 63", bl_q[0]); end
      n_checks++; if (ad_q[0] !== 30'h0) begin n_fail++; $display("FAIL short_addr0 got %h want 0", ad_q[0]); end
      n_checks++; if (bl_q[1] !== 6'd35) begin n_fail++; $display("FAIL short_bl1 got %0d want 35", bl_q[1]); end
      n_checks++; if (ad_q[1] !== 30'h100) begin n_fail++; $display("FAIL short_addr1 got %h want 100", ad_q[1]); end
      n_checks++; if (fall_cyc !== cmd_cyc_q[1] + 1) begin n_fail++; $display("FAIL short_busy_fall got cycle %0d want %0d", fall_cyc, cmd_cyc_q[1] + 1); end
    end
    n_checks++; if (push_q.size() !== 100) begin n_fail++; $display("FAIL short_push_count got %0d want 100", push_q.size()); end
    for (int i = 0; i < push_q.size(); i++) begin
      n_checks++; if (push_q[i] !== exp_word(i, 1'b0)) begin n_fail++; $display("FAIL short_data[%0d] got %h want %h", i, push_q[i], exp_word(i, 1'b0)); end
    end
  endtask

  task automatic test_full_stall();
    bit ok;
    sel = 0;
    clear_logs();
    pulse_start(0, 30'd0);
    wait_pushes(20, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_reach20 got %0d pushes want 20", push_q.size()); end
    tick();
    full = 1'b1;
    repeat (5) tick();
    full = 1'b0;
    wait_idle(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout busy still %b want 0", m_busy); end
    n_checks++; if (push_q.size() !== 640) begin n_fail++; $display("FAIL stall_push_count got %0d want 640", push_q.size()); end
    for (int i = 0; i < push_q.size(); i++) begin
      n_checks++; if (push_q[i] !== exp_word(i, 1'b0)) begin n_fail++; $display("FAIL stall_data[%0d] got %h want %h", i, push_q[i], exp_word(i, 1'b0)); end
    end
    if (push_cyc_q.size() >= 64) begin
      n_checks++; if (push_cyc_q[63] - push_cyc_q[0] + 1 !== 69) begin n_fail++; $display("FAIL stall_burst_span got %0d want 69", push_cyc_q[63] - push_cyc_q[0] + 1); end
    end
    n_checks++; if (bl_q.size() !== 10) begin n_fail++; $display("FAIL stall_cmd_count got %0d want 10", bl_q.size()); end
`ifdef MEM_DISPATCHER_WR_STATS_EN
    n_checks++; if (stall_a !== 16'd5) begin n_fail++; $display("FAIL stall_cycles got %0d want 5", stall_a); end
`endif
  endtask

  task automatic test_ignored_starts();
    bit ok;
    sel = 0;
    clear_logs();
    calib = 1'b0;
    pulse_start(0, 30'h3000);
    repeat (10) tick();
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL nocal_busy got %b want 0", busy_a); end
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL nocal_pushes got %0d want 0", push_q.size()); end
    n_checks++; if (bl_q.size() !== 0) begin n_fail++; $display("FAIL nocal_cmds got %0d want 0", bl_q.size()); end
    calib = 1'b1;
    pulse_start(0, 30'd0);
    repeat (30) tick();
    pulse_start(0, 30'h5000);
    wait_idle(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busystart_timeout busy still %b want 0", m_busy); end
    repeat (100) tick();
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busystart_restarted got %b want 0", busy_a); end
    n_checks++; if (bl_q.size() !== 10) begin n_fail++; $display("FAIL busystart_cmds got %0d want 10", bl_q.size()); end
    for (int i = 0; i < bl_q.size(); i++) begin
      n_checks++; if (ad_q[i] !== 30'(i * 256)) begin n_fail++; $display("FAIL busystart_addr[%0d] got %h want %h", i, ad_q[i], i * 256); end
    end
    n_checks++; if (push_q.size() !== 640) begin n_fail++; $display("FAIL busystart_pushes got %0d want 640", push_q.size()); end
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    sel = 0;
    clear_logs();
    pulse_start(0, 30'd0);
    wait_pushes(20, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach20 got %0d pushes want 20", push_q.size()); end
    tick();
    reset = 1'b1;
    tick();
    @(negedge c3_clk0);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy_a); end
    n_checks++; if (ifa.port_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_en got %b want 0", ifa.port_wr_en); end
    n_checks++; if (ifa.port_cmd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_en got %b want 0", ifa.port_cmd_en); end
    n_checks++; if (ifa.data_in__addr !== 10'd0) begin n_fail++; $display("FAIL rstmid_addr got %0d want 0", ifa.data_in__addr); end
    n_checks++; if (ifa.port_wr_data_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_wr_data got %h want 0", ifa.port_wr_data_out); end
    n_checks++; if ({ifa.port_cmd_bl, ifa.port_cmd_byte_addr} !== 36'd0) begin n_fail++; $display("FAIL rstmid_cmd_fields got %h want 0", {ifa.port_cmd_bl, ifa.port_cmd_byte_addr}); end
    tick();
    reset = 1'b0;
    tick();
    clear_logs();
    pulse_start(0, 30'h0000A000);
    wait_idle(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout busy still %b want 0", m_busy); end
    n_checks++; if (bl_q.size() !== 10) begin n_fail++; $display("FAIL rstmid_cmds got %0d want 10", bl_q.size()); end
    if (bl_q.size() > 0) begin
      n_checks++; if (ad_q[0] !== 30'hA000) begin n_fail++; $display("FAIL rstmid_addr0 got %h want a000", ad_q[0]); end
    end
    n_checks++; if (push_q.size() !== 640) begin n_fail++; $display("FAIL rstmid_pushes got %0d want 640", push_q.size()); end
    for (int i = 0; i < push_q.size(); i++) begin
      n_checks++; if (push_q[i] !== exp_word(i, 1'b0)) begin n_fail++; $display("FAIL rstmid_data[%0d] got %h want %h", i, push_q[i], exp_word(i, 1'b0)); end
    end
  endtask

  task automatic test_wide_port();
    bit ok;
    sel = 2;
    clear_logs();
    pulse_start(2, 30'd0);
    wait_idle(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wide_timeout busy still %b want 0", m_busy); end
    n_checks++; if (bl_q.size() !== 2) begin n_fail++; $display("FAIL wide_cmd_count got %0d want 2", bl_q.size()); end
    if (bl_q.size() == 2) begin
      n_checks++; if (bl_q[0] !== 6'd63 || bl_q[1] !== 6'd63) begin n_fail++; $display("FAIL wide_bl got %0d/%0d want 63/63", bl_q[0], bl_q[1]); end
      n_checks++; if (ad_q[0] !== 30'h0) begin n_fail++; $display("FAIL wide_addr0 got %h want 0", ad_q[0]); end
      n_checks++; if (ad_q[1] !== 30'h200) begin n_fail++; $display("FAIL wide_addr1 got %h want 200", ad_q[1]); end
    end
    n_checks++; if (push_q.size() !== 128) begin n_fail++; $display("FAIL wide_push_count got %0d want 128", push_q.size()); end
    for (int i = 0; i < push_q.size(); i++) begin
      n_checks++; if (push_q[i] !== exp_word(i, 1'b1)) begin n_fail++; $display("FAIL wide_data[%0d] got %h want %h", i, push_q[i], exp_word(i, 1'b1)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_short_block();
    test_full_stall();
    test_ignored_starts();
    test_reset_mid_fill();
    test_wide_port();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
